// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the Wishbone N-way bridge family.
package wb_bridge_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [WB_DATA_W-1:0] TIMEOUT_DATA_BASE = 32'hDEAD_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    ERR
  } state_e;

endpackage

// File: rtl/wb_bridge_nway_if.sv
// Bus bundle for wb_bridge_nway: upstream classic slave side plus broadcast/per-port downstream side.
// Modport slave is the bridge's view; master is the environment (CPU + downstream blocks) view.
interface wb_bridge_nway_if
  import wb_bridge_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_ADDR_WIDTH = 10
);

  logic                           wbs_stb_i;
  logic                           wbs_cyc_i;
  logic                           wbs_we_i;
  logic [WB_SEL_W-1:0]            wbs_sel_i;
  logic [WB_DATA_W-1:0]           wbs_dat_i;
  logic [31:0]                    wbs_adr_i;
  logic                           wbs_ack_o;
  logic [WB_DATA_W-1:0]           wbs_dat_o;

  logic [NUM_PORTS-1:0]           wbm_stb_o;
  logic [NUM_PORTS-1:0]           wbm_cyc_o;
  logic                           wbm_we_o;
  logic [WB_SEL_W-1:0]            wbm_sel_o;
  logic [WB_DATA_W-1:0]           wbm_dat_o;
  logic [PORT_ADDR_WIDTH-1:0]     wbm_adr_o;
  logic [NUM_PORTS-1:0]           wbm_ack_i;
  logic [WB_DATA_W*NUM_PORTS-1:0] wbm_dat_i;

  logic                           bridge_err_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o,
    input  wbm_ack_i, wbm_dat_i,
    output bridge_err_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o,
    output wbm_ack_i, wbm_dat_i,
    input  bridge_err_o
  );

endinterface

// File: rtl/wb_bridge_decode.sv
// Combinational address decode: base-window hit plus downstream port index.
module wb_bridge_decode #(
  parameter int          NUM_PORTS      = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          BASE_MATCH_LSB = 20,
  parameter int          PORT_SEL_LSB   = 16,
  parameter int          IDX_W          = $clog2(NUM_PORTS)
) (
  input  logic [31:PORT_SEL_LSB] wbs_adr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o
);

  localparam int FIELD_W = BASE_MATCH_LSB - PORT_SEL_LSB;

  logic               hit;
  logic [FIELD_W-1:0] field;

  assign hit   = (wbs_adr_i[31:BASE_MATCH_LSB] == BASE_ADDR[31:BASE_MATCH_LSB]);
  // The whole gap up to the base-match bits is compared, so an index past the
  // last port (e.g. 4 of 4) errors instead of aliasing onto a low port.
  assign field   = wbs_adr_i[BASE_MATCH_LSB-1:PORT_SEL_LSB];
  assign valid_o = hit && (32'(field) < 32'(NUM_PORTS));
  assign idx_o   = field[IDX_W-1:0];

endmodule

// File: rtl/wb_bridge_nway.sv
// One upstream Wishbone classic slave fanned out to NUM_PORTS downstream masters.
// Optional build macro WB_BRIDGE_TIMEOUT_EN adds a downstream ack timeout.
module wb_bridge_nway
  import wb_bridge_pkg::*;
#(
  parameter int          NUM_PORTS       = 4,
  parameter int          PORT_ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          BASE_MATCH_LSB  = 20,
  parameter int          PORT_SEL_LSB    = 16,
`ifdef WB_BRIDGE_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES  = 255,
`endif
  parameter logic [31:0] DECODE_ERR_DATA = 32'hBADD_ADD5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_bridge_nway_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       we_q, we_d;
  logic [WB_SEL_W-1:0]        sel_q, sel_d;
  logic [WB_DATA_W-1:0]       wdat_q, wdat_d;
  logic [PORT_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_W-1:0]       rdat_q, rdat_d;

  logic                       dec_valid;
  logic [IDX_W-1:0]           dec_idx;
  logic [NUM_PORTS-1:0]       port_en;
  logic                       up_req;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  wb_bridge_decode #(
    .NUM_PORTS      (NUM_PORTS),
    .BASE_ADDR      (BASE_ADDR),
    .BASE_MATCH_LSB (BASE_MATCH_LSB),
    .PORT_SEL_LSB   (PORT_SEL_LSB),
    .IDX_W          (IDX_W)
  ) u_decode (
    .wbs_adr_i (bus.wbs_adr_i[31:PORT_SEL_LSB]),
    .valid_o   (dec_valid),
    .idx_o     (dec_idx)
  );

  assign up_req = bus.wbs_cyc_i && bus.wbs_stb_i;

  always_comb begin
    // NOTE: every always_comb target gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    adr_d   = adr_q;
    rdat_d  = rdat_q;
`ifdef WB_BRIDGE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (up_req && dec_valid) begin
          idx_d   = dec_idx;
          we_d    = bus.wbs_we_i;
          sel_d   = bus.wbs_sel_i;
          wdat_d  = bus.wbs_dat_i;
          adr_d   = bus.wbs_adr_i[PORT_ADDR_WIDTH-1:0];
`ifdef WB_BRIDGE_TIMEOUT_EN
          tmo_d   = '0;
`endif
          state_d = REQ;
        end else if (up_req) begin
          rdat_d  = DECODE_ERR_DATA;
          state_d = ERR;
        end
      end
      REQ: begin
        // Upstream abort beats a same-cycle downstream ack.
        if (!bus.wbs_cyc_i) begin
          state_d = IDLE;
        end else if (bus.wbm_ack_i[idx_q]) begin
          rdat_d  = bus.wbm_dat_i[idx_q*WB_DATA_W +: WB_DATA_W];
          state_d = RESP;
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rdat_d  = TIMEOUT_DATA_BASE | WB_DATA_W'(idx_q);
          state_d = ERR;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: the captured datapath is reset as well because it drives
      // outputs directly and those must read 0 during reset.
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      adr_q   <= '0;
      rdat_q  <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      adr_q   <= adr_d;
      rdat_q  <= rdat_d;
`ifdef WB_BRIDGE_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Strobe/cycle decode straight from state, so reset drops them without an edge.
  always_comb begin
    port_en = '0;
    if (state_q == REQ) port_en[idx_q] = 1'b1;
  end

  assign bus.wbm_stb_o    = port_en;
  assign bus.wbm_cyc_o    = port_en;
  assign bus.wbm_we_o     = we_q;
  assign bus.wbm_sel_o    = sel_q;
  assign bus.wbm_dat_o    = wdat_q;
  assign bus.wbm_adr_o    = adr_q;
  assign bus.wbs_ack_o    = (state_q == RESP) || (state_q == ERR);
  assign bus.wbs_dat_o    = rdat_q;
  assign bus.bridge_err_o = (state_q == ERR);

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Directed bench for wb_bridge_nway with a queue-based upstream response scoreboard.
// Define WB_BRIDGE_TIMEOUT_EN to also exercise the timeout build (TIMEOUT_CYCLES=8).
module tb_wb_bridge_nway;
  import wb_bridge_pkg::*;

  localparam int NP = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bridge_nway_if #(.NUM_PORTS(NP), .PORT_ADDR_WIDTH(10)) bus ();

  wb_bridge_nway #(
    .NUM_PORTS       (NP),
    .PORT_ADDR_WIDTH (10),
    .BASE_ADDR       (32'h3000_0000),
    .BASE_MATCH_LSB  (20),
    .PORT_SEL_LSB    (16),
`ifdef WB_BRIDGE_TIMEOUT_EN
    .TIMEOUT_CYCLES  (8),
`endif
    .DECODE_ERR_DATA (32'hBADD_ADD5)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int          total = 0;
  int          bad   = 0;
  resp_t       sb_q[$];
  int          ack_dly[NP];
  logic [31:0] rd[NP];
  logic [NP-1:0] stray_ack = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream model: port k acks on its ack_dly[k]-th strobe cycle (0 = never).
  initial begin : responder
    int stb_cnt;
    logic [NP-1:0] ack_v;
    stb_cnt = 0;
    bus.wbm_ack_i = '0;
    forever begin
      @(posedge clk); #1;
      ack_v = '0;
      if (!rst && bus.wbm_stb_o != '0) begin
        stb_cnt++;
        for (int k = 0; k < NP; k++)
          if (bus.wbm_stb_o[k] && ack_dly[k] != 0 && stb_cnt == ack_dly[k]) ack_v[k] = 1'b1;
      end else begin
        stb_cnt = 0;
      end
      bus.wbm_ack_i = ack_v | stray_ack;
      stray_ack = '0;
    end
  end

  // Monitor: pops one expected response per upstream ack cycle.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.wbs_ack_o), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_data", bus.wbs_dat_o, e.data);
          check("resp_err", 32'(bus.bridge_err_o), 32'(e.err));
        end
      end else if (bus.bridge_err_o === 1'b1) begin
        check("err_without_ack", 32'(bus.bridge_err_o), 32'd0);
      end
      if (bus.wbm_stb_o != '0)
        check("stb_onehot", 32'($countones(bus.wbm_stb_o)), 32'd1);
    end
  end

  task automatic drive_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = dat;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
  endtask

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
  endtask

  // Full transaction; exp_port < 0 means no downstream strobe is expected.
  task automatic wb_xfer(input string tag, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat, input int exp_port,
                         input logic [31:0] exp_data, input logic exp_err, output int waited);
    resp_t e;
    logic  got;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive_req(adr, we, sel, dat);
    @(negedge clk);
    check({tag, "_lat_stb"}, 32'(bus.wbm_stb_o), 32'd0);
    @(negedge clk);
    if (exp_port >= 0) begin
      check({tag, "_stb"}, 32'(bus.wbm_stb_o), 32'(1 << exp_port));
      check({tag, "_cyc"}, 32'(bus.wbm_cyc_o), 32'(1 << exp_port));
      check({tag, "_adr"}, 32'(bus.wbm_adr_o), 32'(adr[9:0]));
      check({tag, "_we"},  32'(bus.wbm_we_o),  32'(we));
      check({tag, "_sel"}, 32'(bus.wbm_sel_o), 32'(sel));
      check({tag, "_dat"}, bus.wbm_dat_o, dat);
    end else begin
      check({tag, "_no_stb"}, 32'(bus.wbm_stb_o), 32'd0);
    end
    got    = bus.wbs_ack_o;
    waited = 0;
    while (!got && waited < 40) begin
      @(negedge clk);
      waited++;
      got = bus.wbs_ack_o;
    end
    if (!got) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin : stimulus
    int w;
    rd[0] = 32'h0A0A_0000; rd[1] = 32'h1111_1111;
    rd[2] = 32'h1234_5678; rd[3] = 32'h3333_3333;
    ack_dly[0] = 1; ack_dly[1] = 0; ack_dly[2] = 2; ack_dly[3] = 1;
    bus.wbm_dat_i = {rd[3], rd[2], rd[1], rd[0]};
    idle_bus();

    // Reset state
    @(negedge clk);
    check("rst_ack",  32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat",  bus.wbs_dat_o,      32'd0);
    check("rst_stb",  32'(bus.wbm_stb_o), 32'd0);
    check("rst_err",  32'(bus.bridge_err_o), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Read port 2, ack 2 cycles into the strobe
    wb_xfer("rd_p2", 32'h3002_0010, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678, 1'b0, w);
    check("rd_p2_ack_cycles", 32'(w), 32'd2);

    // Write port 0; wbs_dat_o returns the captured port-0 slice
    wb_xfer("wr_p0", 32'h3000_0004, 1'b1, 4'b0011, 32'hCAFE_F00D, 0, 32'h0A0A_0000, 1'b0, w);
    check("wr_p0_ack_cycles", 32'(w), 32'd1);

    // Decode errors: index past last port, and outside the base window
    wb_xfer("err_idx", 32'h3004_0000, 1'b0, 4'hF, 32'h0, -1, 32'hBADD_ADD5, 1'b1, w);
    check("err_idx_ack_cycles", 32'(w), 32'd0);
    wb_xfer("err_base", 32'h2000_0000, 1'b0, 4'hF, 32'h0, -1, 32'hBADD_ADD5, 1'b1, w);

    // Abort on port 1 with a stray ack on unselected port 0
    @(posedge clk); #1;
    drive_req(32'h3001_0020, 1'b0, 4'hF, 32'h0);
    @(negedge clk); @(negedge clk);
    check("abort_stb", 32'(bus.wbm_stb_o), 32'b0010);
    stray_ack = 4'b0001;
    repeat (2) @(negedge clk);
    check("stray_ignored_stb", 32'(bus.wbm_stb_o), 32'b0010);
    check("stray_ignored_ack", 32'(bus.wbs_ack_o), 32'd0);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    check("abort_cyc_hold", 32'(bus.wbm_cyc_o), 32'b0010);
    @(negedge clk);
    check("abort_cyc_drop", 32'(bus.wbm_cyc_o), 32'd0);
    repeat (3) @(negedge clk);
    wb_xfer("rd_p3", 32'h3003_0008, 1'b0, 4'hF, 32'h0, 3, 32'h3333_3333, 1'b0, w);

    // Reset mid-REQ, away from any clock edge
    @(posedge clk); #1;
    drive_req(32'h3001_0040, 1'b1, 4'b1100, 32'h5555_AAAA);
    repeat (3) @(negedge clk);
    check("pre_rst_cyc", 32'(bus.wbm_cyc_o), 32'b0010);
    #2 rst = 1'b1;
    #1;
    check("midrst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("midrst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("midrst_we",  32'(bus.wbm_we_o),  32'd0);
    check("midrst_dat", bus.wbm_dat_o,      32'd0);
    check("midrst_rdat", bus.wbs_dat_o,     32'd0);
    check("midrst_ack", 32'(bus.wbs_ack_o), 32'd0);
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_stb", 32'(bus.wbm_stb_o), 32'd0);
    wb_xfer("post_rst_p2", 32'h3002_0100, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678, 1'b0, w);

`ifdef WB_BRIDGE_TIMEOUT_EN
    ack_dly[3] = 0;
    wb_xfer("tmo_p3", 32'h3003_0000, 1'b0, 4'hF, 32'h0, 3, 32'hDEAD_0003, 1'b1, w);
    check("tmo_req_cycles", 32'(w), 32'd8);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
